// File: rtl/branch_resolve_unit_if.sv
// Decode/AGEX <-> branch resolve unit bundle: prediction push, resolve, predictor update and
// redirect.
interface branch_resolve_unit_if #(
    parameter int unsigned DBITS  = 32,
    parameter int unsigned BPBITS = 8
);
    logic                      push_valid;
    logic                      push_ready;
    logic [DBITS-1:0]          push_pc;
    logic [BPBITS-1:0]         push_idx;
    logic                      push_taken;
    logic [DBITS-1:0]          push_target;
    logic                      res_valid;
    logic                      res_taken;
    logic [DBITS-1:0]          res_target;
    logic [2+BPBITS+DBITS-1:0] to_BP;
    logic                      redirect_valid;
    logic [DBITS-1:0]          redirect_pc;
    logic                      underflow_err;
    logic [31:0]               stat_branches;
    logic [31:0]               stat_mispred;

    modport master (
        output push_valid, push_pc, push_idx, push_taken, push_target,
        output res_valid, res_taken, res_target,
        input  push_ready, to_BP, redirect_valid, redirect_pc, underflow_err,
        input  stat_branches, stat_mispred
    );

    modport slave (
        input  push_valid, push_pc, push_idx, push_taken, push_target,
        input  res_valid, res_taken, res_target,
        output push_ready, to_BP, redirect_valid, redirect_pc, underflow_err,
        output stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of decode-time branch predictions, resolved against AGEX outcomes.
// Define BRU_STATS_EN to build the resolved/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned DBITS  = 32,
    parameter int unsigned BPBITS = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DBITS-1:0]  pc_q     [DEPTH];
    logic [BPBITS-1:0] idx_q    [DEPTH];
    logic              taken_q  [DEPTH];
    logic [DBITS-1:0]  target_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic              val_q, val_d, dir_q, dir_d;
    logic [BPBITS-1:0] uidx_q, uidx_d;
    logic [DBITS-1:0]  utgt_q, utgt_d;
    logic              redir_q, redir_d;
    logic [DBITS-1:0]  redir_pc_q, redir_pc_d;
    logic              uflow_q, uflow_d;

    logic             full, push_fire, res_fire, mispredict, wr_en;
    logic [DBITS-1:0] actual_next;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        push_fire   = bus.push_valid && !full;
        res_fire    = bus.res_valid && (count_q != '0);
        actual_next = bus.res_taken ? bus.res_target : pc_q[rd_ptr_q] + DBITS'(4);
        mispredict  = res_fire && ((taken_q[rd_ptr_q] != bus.res_taken) ||
                                   (target_q[rd_ptr_q] != actual_next));
        // A push alongside a mispredict is on the wrong path and is dropped.
        wr_en       = push_fire && !mispredict;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispredict) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
            if (res_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_fire) - CW'(res_fire);
        end

        val_d      = res_fire;
        dir_d      = res_fire && bus.res_taken;
        uidx_d     = res_fire ? idx_q[rd_ptr_q] : '0;
        utgt_d     = res_fire ? actual_next : '0;
        redir_d    = mispredict;
        redir_pc_d = res_fire ? actual_next : '0;
        uflow_d    = uflow_q || (bus.res_valid && (count_q == '0));
    end

    // Entry storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_q[wr_ptr_q]     <= bus.push_pc;
            idx_q[wr_ptr_q]    <= bus.push_idx;
            taken_q[wr_ptr_q]  <= bus.push_taken;
            target_q[wr_ptr_q] <= bus.push_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            val_q      <= 1'b0;
            dir_q      <= 1'b0;
            uidx_q     <= '0;
            utgt_q     <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            uflow_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            val_q      <= val_d;
            dir_q      <= dir_d;
            uidx_q     <= uidx_d;
            utgt_q     <= utgt_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            uflow_q    <= uflow_d;
        end
    end

    assign bus.push_ready     = !full;
    assign bus.to_BP          = {val_q, dir_q, uidx_q, utgt_q};
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.underflow_err  = uflow_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (res_fire && (stat_br_q != '1))   stat_br_d = stat_br_q + 32'd1;
        if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bus.stat_branches = stat_br_q;
    assign bus.stat_mispred  = stat_mp_q;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit; expected packets are queued as stimulus
// is driven and compared when the registered outputs appear.
module tb_branch_resolve_unit;
    localparam int unsigned DEPTH = 4;
`ifdef BRU_STATS_EN
    localparam bit StatEn = 1'b1;
`else
    localparam bit StatEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  idx;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [41:0] tobp;
        logic        rv;
        logic [31:0] rpc;
    } pkt_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DBITS(32), .BPBITS(8)) bus ();

    branch_resolve_unit #(.DBITS(32), .BPBITS(8), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t mq[$];
    pkt_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic ufl_m = 1'b0;
    int unsigned sb_m = 0;
    int unsigned mb_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step(input logic pv, input logic [31:0] ppc, input logic [7:0] pidx,
                        input logic ptk, input logic [31:0] ptgt,
                        input logic rv, input logic rtk, input logic [31:0] rtgt);
        pkt_t want, got;
        ent_t e, n;
        logic [31:0] an;
        logic misp, can_push;
        bus.push_valid = pv;  bus.push_pc = ppc;  bus.push_idx = pidx;
        bus.push_taken = ptk; bus.push_target = ptgt;
        bus.res_valid = rv;   bus.res_taken = rtk; bus.res_target = rtgt;
        #1;
        can_push = (mq.size() < DEPTH);
        check("push_ready", 64'(bus.push_ready), 64'(can_push));
        n.pc = ppc; n.idx = pidx; n.tk = ptk; n.tgt = ptgt;
        want.tobp = '0; want.rv = 1'b0; want.rpc = '0;
        if (rv && mq.size() != 0) begin
            e = mq.pop_front();
            an = rtk ? rtgt : e.pc + 32'd4;
            misp = (e.tk != rtk) || (e.tgt != an);
            want.tobp = {1'b1, rtk, e.idx, an};
            want.rv = misp;
            want.rpc = an;
            sb_m++;
            if (misp) begin
                mb_m++;
                mq.delete();
            end else if (pv && can_push) begin
                mq.push_back(n);
            end
        end else begin
            if (rv) ufl_m = 1'b1;
            if (pv && can_push) mq.push_back(n);
        end
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("to_BP", 64'(bus.to_BP), 64'(got.tobp));
        check("redirect_valid", 64'(bus.redirect_valid), 64'(got.rv));
        check("redirect_pc", 64'(bus.redirect_pc), 64'(got.rpc));
        check("underflow_err", 64'(bus.underflow_err), 64'(ufl_m));
        check("stat_branches", 64'(bus.stat_branches), StatEn ? 64'(sb_m) : 64'd0);
        check("stat_mispred", 64'(bus.stat_mispred), StatEn ? 64'(mb_m) : 64'd0);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_idx = '0;
        bus.push_taken = 1'b0; bus.push_target = '0;
        bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
        #3;
        check("rst_to_BP", 64'(bus.to_BP), 64'd0);
        check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check("rst_underflow", 64'(bus.underflow_err), 64'd0);
        check("rst_push_ready", 64'(bus.push_ready), 64'd1);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: correctly predicted taken branch
        step(1'b1, 32'h100, 8'h40, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        check("t1_to_BP", 64'(bus.to_BP), 64'({1'b1, 1'b1, 8'h40, 32'h200}));
        check("t1_no_redirect", 64'(bus.redirect_valid), 64'd0);

        // 2: predicted not-taken, actually taken
        step(1'b1, 32'h104, 8'h41, 1'b0, 32'h108, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        check("t2_redirect_valid", 64'(bus.redirect_valid), 64'd1);
        check("t2_redirect_pc", 64'(bus.redirect_pc), 64'h300);
        check("t2_to_BP", 64'(bus.to_BP), 64'({1'b1, 1'b1, 8'h41, 32'h300}));
        idle();
        check("t2_redirect_pulse", 64'(bus.redirect_valid), 64'd0);
`ifdef BRU_STATS_EN
        check("t6_stat_branches", 64'(bus.stat_branches), 64'd2);
        check("t6_stat_mispred", 64'(bus.stat_mispred), 64'd1);
`endif

        // 3: fill, refused push, refused push alongside a correct resolve
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1000 + 32'(i * 4), 8'(8'h10 + i), 1'b0, 32'h1004 + 32'(i * 4),
                 1'b0, 1'b0, 32'h0);
        check("t3_full", 64'(bus.push_ready), 64'd0);
        step(1'b1, 32'h2000, 8'hEE, 1'b0, 32'h2004, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h2000, 8'hEF, 1'b0, 32'h2004, 1'b1, 1'b0, 32'h0);
        check("t3_ready_after_pop", 64'(bus.push_ready), 64'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();

        // 4: mispredict flush with a concurrent push, then resolve on empty
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3000 + 32'(i * 4), 8'(8'h20 + i), 1'b1, 32'h4000,
                 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h300C, 8'h23, 1'b1, 32'h4000, 1'b1, 1'b0, 32'h0);
        check("t4_redirect", 64'(bus.redirect_valid), 64'd1);
        check("t4_redirect_pc", 64'(bus.redirect_pc), 64'h3004);
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000);
        check("t4_underflow", 64'(bus.underflow_err), 64'd1);
        check("t4_no_update", 64'(bus.to_BP[41]), 64'd0);

        // 5: wrap through the circular buffer; the empty-queue slot gets a fresh push
        step(1'b1, 32'h5000, 8'h50, 1'b1, 32'h6000, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 10; i++)
            step(1'b1, 32'h5000 + 32'(i * 4), 8'(8'h50 + i), 1'b1, 32'h6000 + 32'(i * 16),
                 1'b1, 1'b1, 32'h6000 + 32'((i - 1) * 16));
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000 + 32'(9 * 16));
        check("t5_last_idx", 64'(bus.to_BP[39:32]), 64'h59);
        check("t5_no_redirect", 64'(bus.redirect_valid), 64'd0);

        // 6: asynchronous reset mid-stream with an output pulse live and entries queued
        step(1'b1, 32'h7000, 8'h70, 1'b0, 32'h7004, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h7004, 8'h71, 1'b0, 32'h7008, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        bus.res_valid = 1'b0;
        bus.push_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rr_to_BP", 64'(bus.to_BP), 64'd0);
        check("rr_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        check("rr_underflow", 64'(bus.underflow_err), 64'd0);
        check("rr_stat_branches", 64'(bus.stat_branches), 64'd0);
        check("rr_stat_mispred", 64'(bus.stat_mispred), 64'd0);
        mq.delete();
        ufl_m = 1'b0;
        sb_m = 0;
        mb_m = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Queue must be empty after reset, so this resolve is an underflow.
        step(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("rr_queue_empty", 64'(bus.underflow_err), 64'd1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- AGEX-side counterpart to the branch predictor.
- Records each prediction issued at decode in an in-order queue, resolves it against the actual outcome computed in AGEX, and emits the predictor update packet {val_update, update_dir, update_idx, update_target}.
- Detects mispredictions, redirects fetch to the correct PC, and discards wrong-path queue entries.

Parameters:
- DBITS, 32, data/PC width.
- BPBITS, 8, predictor index width (PC[9:2] XOR history).
- DEPTH, 4, in-flight branch queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- push_valid  in  1  decode records a predicted branch this cycle.
- push_ready  out  1  queue can accept; equals !full.
- push_pc  in  DBITS  branch PC.
- push_idx  in  BPBITS  predictor index used for this prediction.
- push_taken  in  1  predicted direction.
- push_target  in  DBITS  predicted next PC.
- res_valid  in  1  AGEX resolves the oldest branch this cycle.
- res_taken  in  1  actual direction.
- res_target  in  DBITS  actual taken target.
- to_BP  out  2+BPBITS+DBITS  {val_update, update_dir, update_idx, update_target}.
- redirect_valid  out  1  mispredict; fetch must restart.
- redirect_pc  out  DBITS  correct next PC.
- underflow_err  out  1  sticky: resolve arrived with queue empty.
- stat_branches  out  32  resolved-branch count (Optional Feature).
- stat_mispred  out  32  mispredict count (Optional Feature).

Behaviour:
- Reset (async): all outputs 0, queue empty, read/write pointers 0, count 0, underflow_err 0.
- Queue is a circular buffer; pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- full = (count == DEPTH), from registered state only. push_ready does not depend on res_valid.
- A push is accepted when push_valid && push_ready.
- Resolution:
  - When res_valid && count != 0, pop the head entry E.
  - Compute actual_next = res_taken ? res_target : E.pc + 4 (modulo 2^DBITS).
  - mispredict = (E.taken != res_taken) || (E.target != actual_next).
- Outputs are registered, 1-cycle latency after the res_valid cycle. Each pulses for exactly one cycle per resolve:
  - val_update = 1, update_dir = res_taken, update_idx = E.idx, update_target = actual_next.
  - redirect_valid = mispredict, redirect_pc = actual_next.
- Mispredict flush: on a mispredicting resolve, all younger entries are discarded. count becomes 0; rd_ptr = wr_ptr.
- Simultaneous push and mispredicting resolve: the push is wrong-path and is dropped; the queue ends empty.
- Simultaneous push and correct resolve: both take effect; count unchanged. If the queue was full, push_ready = 0 and the push is not accepted.
- Resolve while empty:
  - No pop, and to_BP.val_update = 0.
  - underflow_err sets and holds until reset.
  - A push in the same cycle is still accepted.
- Reset asserted mid-operation clears the queue and any pending outputs immediately.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined:
  - stat_branches increments on every successful resolve.
  - stat_mispred increments on every mispredict.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and update in the same cycle as the registered outputs.
  - Both reset to 0.
- When undefined: counters are not instantiated and both ports are constant 0.

Test Plan:
1. Push {pc=0x100, idx=0x40, taken=1, target=0x200}; next cycle res_valid, taken=1, target=0x200 -> one cycle later val_update=1, dir=1, idx=0x40, update_target=0x200, redirect_valid=0, count=0.
2. Push {pc=0x104, taken=0, target=0x108}; resolve taken=1, target=0x300 -> redirect_valid=1, redirect_pc=0x300, update_dir=1, update_target=0x300.
3. Push 4 entries -> push_ready=0; 5th push ignored. Resolve 1st correctly while pushing -> push still refused that cycle; push_ready=1 next cycle.
4. Push 3 entries; resolve 1st as mispredict while pushing a 4th -> redirect pulses, queue empty; a following res_valid sets underflow_err with val_update=0.
5. Wrap test: 10 push/correct-resolve pairs with DEPTH=4 -> update_idx values return in push order, no spurious redirects.
6. With BRU_STATS_EN defined, run scenarios 1-2 -> stat_branches=2, stat_mispred=1. Then assert reset mid-stream -> all outputs and counters 0 asynchronously.
